// File: rtl/pkt_merger.sv
`default_nettype none
// ============================================================================
// pkt_merger : packet-granular 2:1 merge of data and control AXI-Stream paths
// Rev 1.0
// ============================================================================
module pkt_merger #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int CTRL_FIFO_DEPTH_BITS = 4,
    parameter int MAX_CTRL_BEATS       = 4
) (
    input  logic                                 clk,
    input  logic                                 aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       ctrl_s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     ctrl_s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      ctrl_s_axis_tuser,
    input  logic                                 ctrl_s_axis_tvalid,
    input  logic                                 ctrl_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,
    output logic [15:0]                          ctrl_drop_cnt
);

    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int EW = C_S_AXIS_DATA_WIDTH + KW + C_S_AXIS_TUSER_WIDTH + 1;
    localparam int AW = CTRL_FIFO_DEPTH_BITS;
    localparam int CW = CTRL_FIFO_DEPTH_BITS + 1;
    localparam int IW = $clog2(MAX_CTRL_BEATS + 1);
    localparam logic [CW-1:0] DEPTH     = CW'(2 ** CTRL_FIFO_DEPTH_BITS);
    localparam logic [CW-1:0] MAX_BEATS = CW'(MAX_CTRL_BEATS);
    localparam logic [IW-1:0] LAST_IDX  = IW'(MAX_CTRL_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_DATA = 2'd1,
        SEND_CTRL = 2'd2
    } state_t;

    state_t          state;
    logic            last_grant_ctrl;

    logic [EW-1:0]   fifo_mem [0:(1<<AW)-1];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   ctrl_pkt_cnt;

    logic            in_pkt;
    logic            accepting;
    logic [IW-1:0]   beat_idx;

    logic            first_beat;
    logic            admit;
    logic [IW-1:0]   cur_idx;
    logic            wr_en;
    logic            wr_last;
    logic            rd_en;
    logic [EW-1:0]   head;
    logic            head_last;
    logic            fifo_empty;
    logic            out_adv;
    logic            ld_data;
    logic            ld_ctrl;
    logic            ctrl_req;
    logic            data_req;

    assign first_beat = ~in_pkt;
    assign admit      = (DEPTH - fifo_count) >= MAX_BEATS;
    assign cur_idx    = first_beat ? '0 : beat_idx;
    assign fifo_empty = (fifo_count == '0);
    assign head       = fifo_mem[rd_ptr];
    assign head_last  = head[0];

    // Beats past the MAX_CTRL_BEATS-th are discarded; that beat closes the packet.
    always_comb begin
        wr_en   = 1'b0;
        wr_last = ctrl_s_axis_tlast | (cur_idx == LAST_IDX);
        if (ctrl_s_axis_tvalid && (cur_idx <= LAST_IDX)) begin
            wr_en = first_beat ? admit : accepting;
        end
    end

    assign out_adv       = m_axis_tready | ~m_axis_tvalid;
    assign ld_data       = (state == SEND_DATA) & s_axis_tvalid & out_adv;
    assign ld_ctrl       = (state == SEND_CTRL) & ~fifo_empty & out_adv;
    assign rd_en         = ld_ctrl;
    assign s_axis_tready = (state == SEND_DATA) & out_adv;
    assign ctrl_req      = (ctrl_pkt_cnt != '0);
    assign data_req      = s_axis_tvalid;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr] <= {ctrl_s_axis_tdata, ctrl_s_axis_tkeep, ctrl_s_axis_tuser, wr_last};
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            ctrl_pkt_cnt  <= '0;
            in_pkt        <= 1'b0;
            accepting     <= 1'b0;
            beat_idx      <= '0;
            ctrl_drop_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            case ({wr_en & wr_last, rd_en & head_last})
                2'b10:   ctrl_pkt_cnt <= ctrl_pkt_cnt + CW'(1);
                2'b01:   ctrl_pkt_cnt <= ctrl_pkt_cnt - CW'(1);
                default: ctrl_pkt_cnt <= ctrl_pkt_cnt;
            endcase
            if (ctrl_s_axis_tvalid) begin
                in_pkt <= ~ctrl_s_axis_tlast;
                if (first_beat) begin
                    accepting <= admit;
                    if (!admit && (ctrl_drop_cnt != 16'hFFFF)) begin
                        ctrl_drop_cnt <= ctrl_drop_cnt + 16'd1;
                    end
                end
                if (wr_en) beat_idx <= cur_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= IDLE;
            last_grant_ctrl <= 1'b0;
            m_axis_tvalid   <= 1'b0;
            m_axis_tdata    <= '0;
            m_axis_tkeep    <= '0;
            m_axis_tuser    <= '0;
            m_axis_tlast    <= 1'b0;
        end else begin
            if (ld_data) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tkeep  <= s_axis_tkeep;
                m_axis_tuser  <= s_axis_tuser;
                m_axis_tlast  <= s_axis_tlast;
            end else if (ld_ctrl) begin
                m_axis_tvalid <= 1'b1;
                {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} <= head;
            end else if (out_adv) begin
                m_axis_tvalid <= 1'b0;
            end

            // On a tie the source that did not win last time is granted.
            case (state)
                IDLE: begin
                    if (ctrl_req && (!data_req || !last_grant_ctrl)) begin
                        state           <= SEND_CTRL;
                        last_grant_ctrl <= 1'b1;
                    end else if (data_req) begin
                        state           <= SEND_DATA;
                        last_grant_ctrl <= 1'b0;
                    end
                end
                SEND_DATA: if (ld_data && s_axis_tlast) state <= IDLE;
                SEND_CTRL: if (ld_ctrl && head_last) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_merger.sv
`default_nettype none
// ============================================================================
// tb_pkt_merger : directed self-checking bench with a packet-level output model
// Rev 1.0
// ============================================================================
module tb_pkt_merger;

    localparam int DW   = 256;
    localparam int KW   = DW / 8;
    localparam int UW   = 128;
    localparam int MAXB = 4;

    logic           clk = 1'b0;
    logic           aresetn;
    logic [DW-1:0]  s_axis_tdata;
    logic [KW-1:0]  s_axis_tkeep;
    logic [UW-1:0]  s_axis_tuser;
    logic           s_axis_tvalid;
    logic           s_axis_tlast;
    logic           s_axis_tready;
    logic [DW-1:0]  ctrl_s_axis_tdata;
    logic [KW-1:0]  ctrl_s_axis_tkeep;
    logic [UW-1:0]  ctrl_s_axis_tuser;
    logic           ctrl_s_axis_tvalid;
    logic           ctrl_s_axis_tlast;
    logic [DW-1:0]  m_axis_tdata;
    logic [KW-1:0]  m_axis_tkeep;
    logic [UW-1:0]  m_axis_tuser;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic           m_axis_tready;
    logic [15:0]    ctrl_drop_cnt;

    always #5 clk = ~clk;

    pkt_merger #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .CTRL_FIFO_DEPTH_BITS(4),
        .MAX_CTRL_BEATS      (MAXB)
    ) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tuser      (s_axis_tuser),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tready     (s_axis_tready),
        .ctrl_s_axis_tdata (ctrl_s_axis_tdata),
        .ctrl_s_axis_tkeep (ctrl_s_axis_tkeep),
        .ctrl_s_axis_tuser (ctrl_s_axis_tuser),
        .ctrl_s_axis_tvalid(ctrl_s_axis_tvalid),
        .ctrl_s_axis_tlast (ctrl_s_axis_tlast),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tkeep      (m_axis_tkeep),
        .m_axis_tuser      (m_axis_tuser),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tready     (m_axis_tready),
        .ctrl_drop_cnt     (ctrl_drop_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic  valid;
        beat_t b;
    } centry_t;

    beat_t   dq[$];
    centry_t cq[$];
    beat_t   exp_q[$];
    beat_t   last_out;
    int      out_beats = 0;
    int      n_checks  = 0;
    int      n_pass    = 0;

    task automatic check(string name, logic [255:0] act, logic [255:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // src 1 = data path, 2 = control path; every field encodes src/packet/beat.
    function automatic beat_t mk_beat(int src, int pkt, int idx, logic last);
        beat_t       b;
        logic [31:0] w;
        w      = {src[7:0], pkt[7:0], idx[15:0]};
        b.data = {8{w}};
        b.keep = {pkt[7:0], idx[7:0], 16'hFFFF};
        b.user = {4{w ^ 32'hA5A5_0000}};
        b.last = last;
        return b;
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_data(int pkt, int n);
        for (int i = 0; i < n; i++) dq.push_back(mk_beat(1, pkt, i, i == n - 1));
    endtask

    task automatic send_ctrl(int pkt, int n);
        for (int i = 0; i < n; i++) cq.push_back({1'b1, mk_beat(2, pkt, i, i == n - 1)});
    endtask

    task automatic expect_data(int pkt, int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk_beat(1, pkt, i, i == n - 1));
    endtask

    // Accepted control packet as it must leave: at most MAXB beats, the last one closing it.
    task automatic expect_ctrl(int pkt, int n);
        int kept;
        kept = (n < MAXB) ? n : MAXB;
        for (int i = 0; i < kept; i++) exp_q.push_back(mk_beat(2, pkt, i, i == kept - 1));
    endtask

    task automatic wait_drain(string name, logic [3:0] pat);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            m_axis_tready = pat[c % 4];
            @(posedge clk);
            #1;
            c++;
        end
        check(name, exp_q.size() == 0, 1'b1);
        m_axis_tready = 1'b1;
        cyc(4);
    endtask

    initial begin
        logic  hs;
        beat_t b;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tuser  = '0;   s_axis_tlast = 1'b0;
        forever begin
            @(negedge clk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            #2;
            if (hs && dq.size() > 0) void'(dq.pop_front());
            if (dq.size() > 0) begin
                b = dq[0];
                s_axis_tvalid = 1'b1; s_axis_tdata = b.data; s_axis_tkeep = b.keep;
                s_axis_tuser  = b.user; s_axis_tlast = b.last;
            end else begin
                s_axis_tvalid = 1'b0;
            end
        end
    end

    initial begin
        centry_t e;
        ctrl_s_axis_tvalid = 1'b0; ctrl_s_axis_tdata = '0; ctrl_s_axis_tkeep = '0;
        ctrl_s_axis_tuser  = '0;   ctrl_s_axis_tlast = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (cq.size() > 0) begin
                e = cq.pop_front();
                ctrl_s_axis_tvalid = e.valid; ctrl_s_axis_tdata = e.b.data;
                ctrl_s_axis_tkeep  = e.b.keep; ctrl_s_axis_tuser = e.b.user;
                ctrl_s_axis_tlast  = e.b.last;
            end else begin
                ctrl_s_axis_tvalid = 1'b0;
            end
        end
    end

    initial begin
        beat_t e, cur, prev;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            cur.data = m_axis_tdata; cur.keep = m_axis_tkeep;
            cur.user = m_axis_tuser; cur.last = m_axis_tlast;
            if (!aresetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_tvalid", m_axis_tvalid, 1'b1);
                    check("hold_tdata", cur.data, prev.data);
                    check("hold_tkeep", cur.keep, prev.keep);
                    check("hold_tuser", cur.user, prev.user);
                    check("hold_tlast", cur.last, prev.last);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    out_beats++;
                    last_out = cur;
                    check("beat_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_tdata", cur.data, e.data);
                        check("out_tkeep", cur.keep, e.keep);
                        check("out_tuser", cur.user, e.user);
                        check("out_tlast", cur.last, e.last);
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev       = cur;
            end
        end
    end

    initial begin
        logic [5:0] t1_trdy;
        logic [5:0] t1_mval;
        logic [3:0] t6_mval;
        int         ob;

        aresetn       = 1'b0;
        m_axis_tready = 1'b1;
        cyc(3);
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_m_tdata", m_axis_tdata, '0);
        check("rst_m_tlast", m_axis_tlast, 1'b0);
        check("rst_s_tready", s_axis_tready, 1'b0);
        check("rst_drop_cnt", ctrl_drop_cnt, 16'd0);
        aresetn = 1'b1;
        cyc(2);

        // Single 3-beat data packet: tready cycles 1..3, output cycles 2..4.
        t1_trdy = 6'b001110;
        t1_mval = 6'b011100;
        send_data(1, 3);
        expect_data(1, 3);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("t1_s_tready_c%0d", k), s_axis_tready, t1_trdy[k]);
            check($sformatf("t1_m_tvalid_c%0d", k), m_axis_tvalid, t1_mval[k]);
            if (k == 4) check("t1_last_beat_tlast", m_axis_tlast, 1'b1);
        end
        cyc(1);
        wait_drain("t1_drain", 4'b1111);
        check("t1_drop_cnt", ctrl_drop_cnt, 16'd0);

        // Tie with control complete and data valid: ctrl A, data D2, ctrl B, data D3.
        send_ctrl(2, 2);
        send_ctrl(3, 1);
        expect_ctrl(2, 2);
        expect_data(2, 3);
        expect_ctrl(3, 1);
        expect_data(3, 2);
        cyc(2);
        send_data(2, 3);
        send_data(3, 2);
        wait_drain("t2_drain", 4'b1111);
        check("t2_drop_cnt", ctrl_drop_cnt, 16'd0);

        // Output back-pressure pattern 1,0,0,1.
        ob = out_beats;
        send_data(4, 4);
        expect_data(4, 4);
        wait_drain("t3_drain", 4'b1001);
        check("t3_beat_count", out_beats - ob, 4);

        // 6-beat control packet is truncated to 4 beats.
        ob = out_beats;
        send_ctrl(4, 6);
        expect_ctrl(4, 6);
        wait_drain("t4_drain", 4'b1111);
        check("t4_beat_count", out_beats - ob, 4);
        check("t4_last_tdata", last_out.data, {8{32'h0204_0003}});
        check("t4_last_tlast", last_out.last, 1'b1);
        check("t4_drop_cnt", ctrl_drop_cnt, 16'd0);

        // Five 4-beat control packets under full back-pressure: the fifth is dropped.
        ob = out_beats;
        m_axis_tready = 1'b0;
        for (int p = 0; p < 5; p++) send_ctrl(10 + p, 4);
        for (int p = 0; p < 4; p++) expect_ctrl(10 + p, 4);
        cyc(26);
        check("t5_drop_cnt", ctrl_drop_cnt, 16'd1);
        check("t5_no_output_yet", out_beats - ob, 0);
        check("t5_head_waiting", m_axis_tvalid, 1'b1);
        wait_drain("t5_drain", 4'b1111);
        check("t5_beat_count", out_beats - ob, 16);

        // Reset in the middle of a data packet and a control packet.
        send_data(5, 4);
        expect_data(5, 4);
        send_ctrl(5, 6);
        cyc(4);
        dq.delete();
        cq.delete();
        exp_q.delete();
        aresetn = 1'b0;
        #1;
        check("t6_rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("t6_rst_m_tdata", m_axis_tdata, '0);
        check("t6_rst_m_tkeep", m_axis_tkeep, '0);
        check("t6_rst_m_tuser", m_axis_tuser, '0);
        check("t6_rst_m_tlast", m_axis_tlast, 1'b0);
        check("t6_rst_s_tready", s_axis_tready, 1'b0);
        check("t6_rst_drop_cnt", ctrl_drop_cnt, 16'd0);
        cyc(2);
        aresetn = 1'b1;
        cyc(1);
        t6_mval = 4'b1000;
        send_ctrl(6, 1);
        expect_ctrl(6, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t6_m_tvalid_c%0d", k), m_axis_tvalid, t6_mval[k]);
            if (k == 3) check("t6_first_tdata", m_axis_tdata, {8{32'h0206_0000}});
        end
        cyc(1);
        wait_drain("t6_drain", 4'b1111);
        check("t6_drop_cnt", ctrl_drop_cnt, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
